// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative MIPS multiply/divide unit.
// Holds op/state encodings, the iteration count and the operand magnitude helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = $clog2(MD_ITER);

  // Two's-complement magnitude for signed ops; raw value for unsigned ones.
  function automatic logic [31:0] md_abs32(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Ops with an even encoding (MULT, DIV) treat operands as signed.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the datapath and the multiply/divide unit.
// The unit sits on the slave side; the issuing datapath (or bench) is master.
interface muldiv_if;
  import muldiv_pkg::*;

  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO.
// One 64-bit accumulator is shared: product for multiply, {remainder, quotient} for divide.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam logic [MD_CNT_W-1:0] LAST_CNT = MD_CNT_W'(MD_ITER - 1);

  md_state_e           state_r;
  logic [MD_CNT_W-1:0] cnt_r;
  md_op_e              op_r;
  logic [31:0]         opnd_r;
  logic [63:0]         acc_r;
  logic                neg_prod_r;
  logic                neg_quo_r;
  logic                neg_rem_r;
  logic                div0_r;
  logic                busy_r;
  logic                done_r;
  logic [31:0]         hi_r;
  logic [31:0]         lo_r;

  logic                in_signed_s;
  logic [31:0]         abs_rs_s;
  logic [31:0]         abs_rt_s;
  logic [63:0]         init_acc_s;
  logic [31:0]         init_opnd_s;
  logic [32:0]         mul_sum_s;
  logic [63:0]         mul_next_s;
  logic [64:0]         div_shift_s;
  logic [32:0]         div_diff_s;
  logic [63:0]         div_next_s;
  logic [63:0]         step_s;
  logic [63:0]         prod_s;
  logic [31:0]         res_hi_s;
  logic [31:0]         res_lo_s;

  // Operand capture: multiply keeps the multiplier in acc low half, divide the dividend.
  always_comb begin
    in_signed_s = md_is_signed(bus.op);
    abs_rs_s    = md_abs32(bus.rs_val, in_signed_s);
    abs_rt_s    = md_abs32(bus.rt_val, in_signed_s);
    if (bus.op[1]) begin
      init_acc_s  = {32'd0, abs_rs_s};
      init_opnd_s = abs_rt_s;
    end else begin
      init_acc_s  = {32'd0, abs_rt_s};
      init_opnd_s = abs_rs_s;
    end
  end

  // One iteration step: shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[63:32]};
    end
    mul_next_s  = {mul_sum_s, acc_r[31:1]};
    div_shift_s = {acc_r, 1'b0};
    div_diff_s  = div_shift_s[64:32] - {1'b0, opnd_r};
    // A borrow out of the 33-bit subtract means the trial divisor did not fit.
    if (div_diff_s[32]) begin
      div_next_s = div_shift_s[63:0];
    end else begin
      div_next_s = {div_diff_s[31:0], div_shift_s[31:1], 1'b1};
    end
    if (op_r[1]) begin
      step_s = div_next_s;
    end else begin
      step_s = mul_next_s;
    end
  end

  // Sign correction of the final step, presented to HI/LO on the commit edge.
  always_comb begin
    if (neg_prod_r) begin
      prod_s = 64'd0 - step_s;
    end else begin
      prod_s = step_s;
    end
    if (op_r[1]) begin
      if (div0_r) begin
        res_lo_s = 32'hFFFF_FFFF;
      end else if (neg_quo_r) begin
        res_lo_s = 32'd0 - step_s[31:0];
      end else begin
        res_lo_s = step_s[31:0];
      end
      if (neg_rem_r) begin
        res_hi_s = 32'd0 - step_s[63:32];
      end else begin
        res_hi_s = step_s[63:32];
      end
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
  end

  // Control FSM, operand latch, iteration counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      op_r       <= MD_MULT;
      opnd_r     <= 32'd0;
      acc_r      <= 64'd0;
      neg_prod_r <= 1'b0;
      neg_quo_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div0_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.hi_we) begin
            hi_r <= bus.wdata;
          end
          if (bus.lo_we) begin
            lo_r <= bus.wdata;
          end
          if (bus.start) begin
            state_r    <= RUN;
            busy_r     <= 1'b1;
            cnt_r      <= '0;
            op_r       <= md_op_e'(bus.op);
            acc_r      <= init_acc_s;
            opnd_r     <= init_opnd_s;
            neg_prod_r <= (bus.op == MD_MULT) && (bus.rs_val[31] ^ bus.rt_val[31]);
            neg_quo_r  <= (bus.op == MD_DIV) && (bus.rs_val[31] ^ bus.rt_val[31]);
            neg_rem_r  <= (bus.op == MD_DIV) && bus.rs_val[31];
            div0_r     <= bus.op[1] && (bus.rt_val == 32'd0);
          end
        end
        RUN: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + MD_CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed MULT/DIV vectors with hand-computed HI/LO,
// MTHI/MTLO handling, busy/done timing and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          id;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   op_id;
  exp_t exp_q[$];

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops the oldest expected result and compares HI/LO.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 with no outstanding operation, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.hi !== e.hi || bus.lo !== e.lo) begin
          errors++;
          $display("FAIL result_op%0d: got hi=0x%08h lo=0x%08h expected hi=0x%08h lo=0x%08h",
                   e.id, bus.hi, bus.lo, e.hi, e.lo);
        end
      end
    end
  end

  // Issue one operation at the current falling edge and follow it to its commit edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic noise,
                        input logic hw, input logic lw, input logic [31:0] wd);
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    logic        held;
    int          n;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.hi_we  = hw;
    bus.lo_we  = lw;
    bus.wdata  = wd;
    op_id++;
    exp_q.push_back('{hi: ehi, lo: elo, id: op_id});
    @(negedge clk);
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.rs_val = a ^ 32'h5A5A_A5A5;
    bus.rt_val = ~b;
    bus.op     = ~op;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    chk("done_low_after_accept", {31'd0, bus.done}, 32'd0);
    if (lw) chk("lo_write_with_start", bus.lo, wd);
    if (hw) chk("hi_write_with_start", bus.hi, wd);
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    held    = 1'b1;
    n       = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== hold_hi || bus.lo !== hold_lo) held = 1'b0;
      n++;
      bus.start  = noise && (n % 5 == 0) && (n < 30);
      bus.hi_we  = noise && (n % 5 == 0) && (n < 30);
      bus.lo_we  = noise && (n % 5 == 0) && (n < 30);
      bus.wdata  = 32'hBAD0_0000 + 32'(n);
      bus.rs_val = 32'(n) * 32'd7;
      bus.rt_val = 32'd3;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("busy_cycles", 32'(n), 32'd32);
    chk("hilo_hold_during_run", {31'd0, held}, 32'd1);
    chk("done_at_commit", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    int ndone;
    checks     = 0;
    errors     = 0;
    op_id      = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
    bus.wdata  = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    rst = 1'b0;

    // Idle MTLO, then MTHI+MTLO together.
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h0000_1234);
    chk("mtlo_hi_untouched", bus.hi, 32'd0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi_both_hi", bus.hi, 32'hA5A5_0F0F);
    chk("mtlo_both_lo", bus.lo, 32'hA5A5_0F0F);

    // Back-to-back operations: each new start lands on the edge that clears done.
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_MULT,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_DIV,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    // start/hi_we/lo_we pulses during RUN must be ignored.
    run_op(MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("done_single_pulse", {31'd0, bus.done}, 32'd0);
    // Start together with MTLO while idle: write lands, result overwrites it later.
    run_op(MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 32'h0000_0055);
    @(negedge clk);

    // Reset in the middle of a DIVU: no done pulse, reset values hold.
    bus.start  = 1'b1;
    bus.op     = MD_DIVU;
    bus.rs_val = 32'hFFFF_FFFF;
    bus.rt_val = 32'h0000_0003;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_activity", 32'(ndone), 32'd0);
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("final_done_low", {31'd0, bus.done}, 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, holding the architectural HI/LO registers. It consumes the two register-file read ports (rs value, rt value) and executes MULT, MULTU, DIV and DIVU over 32 cycles. It also services MTHI/MTLO writes. HI/LO feed the MFHI/MFLO path back to register-file write data.

## Interface
- No parameters; iteration count fixed at 32.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request an operation; sampled only when busy=0
- op  in  2  operation select: MULT, MULTU, DIV, DIVU
- rs_val  in  32  multiplicand / dividend (register-file read port 1)
- rt_val  in  32  multiplier / divisor (register-file read port 2)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO hold new result
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states: IDLE, RUN.
- IDLE -> RUN on an edge with start=1:
  - latch op;
  - latch |rs_val| and |rt_val|; absolute value for signed ops, raw for unsigned;
  - latch the result sign flags;
  - clear the 5-bit iteration counter.
- RUN performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. The counter increments each cycle.
- RUN -> IDLE on the 32nd RUN edge (counter = 31). On that same edge:
  - the sign-corrected result is committed to HI/LO;
  - done is set for exactly one cycle.
- Multiply result: HI = product[63:32], LO = product[31:0].
  - MULT: the 64-bit product is negated if the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - DIV: quotient is negated if the operand signs differ.
  - DIV: remainder takes the sign of the dividend.
- Divide by zero, both DIV and DIVU: LO=0xFFFFFFFF, HI=rs_val. Still takes 32 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000 (wraps, no trap).
- MTHI/MTLO, only when busy=0:
  - hi_we=1 loads hi from wdata on the edge; lo_we=1 loads lo from wdata on the edge;
  - both may be asserted together.
- Simultaneous start and hi_we/lo_we while idle: the write takes effect, start is accepted, and the later result overwrites HI/LO.
- start while busy=1: ignored, with no queuing. hi_we/lo_we while busy=1: ignored.
- HI/LO are unchanged between operations and during RUN. Intermediate values never appear on hi/lo.

## Timing
- Reset values: busy=0, done=0, hi=0x00000000, lo=0x00000000, FSM=IDLE, counter=0.
- rst mid-operation aborts the operation. The reset values hold after that edge, with no done pulse.
- Accept edge E0 (start=1, busy=0) makes busy=1 from E0 through E32.
- E32 commits HI/LO, sets busy=0 and sets done=1. done returns to 0 at E33.
- Latency is 32 cycles from accept to result-visible. A new start may be accepted at E32's following edge or later, while done is high.
- rs_val/rt_val/op need only be valid at the accept edge.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - FSM state encodings IDLE/RUN;
  - constant MD_ITER=32.
- Single module with no sub-modules. A 64-bit accumulator/remainder register is shared between multiply and divide datapaths.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 32 cycles, HI=0xFFFFFFFE, LO=0x00000001, done high for exactly one cycle, busy high for exactly 32 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 2 -> LO=3, HI=1.
- DIV 5 / 0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Idle: lo_we=1 with wdata=0x1234 -> lo=0x1234 next edge. During RUN: start, hi_we and lo_we pulses are all ignored, and HI/LO are unchanged until the commit edge.
- rst=1 at cycle 10 of a DIVU -> next edge busy=0, hi=lo=0, no done pulse; a fresh start after rst completes normally.
